// File: rtl/cic_decimating_comb.sv
// cic_decimating_comb
// Decimator plus comb section of the receive-path CIC filter. It keeps one
// integrator sample in every R and runs the decimated stream through STAGES
// pipelined first-difference stages with differential delay 1. The result is
// truncated to OUTPUT_WIDTH and presented with a one-cycle strobe.
//
// Strobe semantics, input and output side alike: the data word is meaningful
// only in a cycle where its strobe is high. There is no back-pressure, so the
// block accepts every strobed sample and emits each result exactly once.
//
// Parameter limits: OUTPUT_WIDTH <= INPUT_WIDTH and 1 <= STAGES <= 8.

module cic_decimating_comb #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int STAGES       = 4,
    parameter int RATE_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [RATE_WIDTH-1:0]   rate,
    input  logic                    strobe_in,
    input  logic [INPUT_WIDTH-1:0]  d_in,
    output logic [OUTPUT_WIDTH-1:0] d_out,
    output logic                    strobe_out
);

    // ------------------------------------------------------------------
    // Decimation-rate handling
    // ------------------------------------------------------------------
    logic [RATE_WIDTH-1:0] rate_sat;     // rate with 0 mapped to 1
    logic [RATE_WIDTH-1:0] rate_q;       // rate in force for the current period
    logic                  rate_loaded;  // rate_q holds a valid value
    logic [RATE_WIDTH-1:0] rate_cur;     // rate used by the capture compare
    logic [RATE_WIDTH-1:0] count;
    logic                  capture;

    assign rate_sat = (rate == '0) ? RATE_WIDTH'(1) : rate;

    // On the first edge after reset rate_q has not been loaded yet, so the
    // compare uses the live (saturated) rate input for that one edge.
    assign rate_cur = rate_loaded ? rate_q : rate_sat;

    // A capture is the R-th strobed sample of the current period.
    assign capture = enable && strobe_in && (count == rate_cur - RATE_WIDTH'(1));

    // Rate latch: reloaded after reset, while disabled, and at each capture, so
    // a rate change never takes effect in the middle of a period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rate_q      <= '0;
            rate_loaded <= 1'b0;
        end else if (!rate_loaded || !enable || capture) begin
            rate_q      <= rate_sat;
            rate_loaded <= 1'b1;
        end
    end

    // Decimation counter: advances only on strobed samples, restarts at a capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (strobe_in) begin
            count <= capture ? '0 : count + RATE_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Decimation register (stage 0 of the pipeline)
    // ------------------------------------------------------------------
    logic [INPUT_WIDTH-1:0] dec_reg;
    logic                   v0;

    // Hold the captured sample and flag it valid for exactly one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_reg <= '0;
            v0      <= 1'b0;
        end else if (!enable) begin
            dec_reg <= '0;
            v0      <= 1'b0;
        end else begin
            v0 <= capture;
            if (capture) begin
                dec_reg <= d_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb chain
    // ------------------------------------------------------------------
    logic [INPUT_WIDTH-1:0] z_q     [STAGES];  // previous input of each stage
    logic [INPUT_WIDTH-1:0] c_q     [STAGES];  // difference output of each stage
    logic [STAGES-1:0]      v_q;               // stage output valid
    logic [INPUT_WIDTH-1:0] x_in    [STAGES];  // input word of each stage
    logic [STAGES-1:0]      x_valid;           // input valid of each stage

    // Wire each stage to its predecessor; stage 0 is fed by the decimator.
    always_comb begin
        x_in    = '{default: '0};
        x_valid = '0;
        x_in[0]    = dec_reg;
        x_valid[0] = v0;
        for (int k = 1; k < STAGES; k++) begin
            x_in[k]    = c_q[k-1];
            x_valid[k] = v_q[k-1];
        end
    end

    // Each stage forms x - z on a valid input and otherwise holds, so gaps in
    // the decimated stream travel through as bubbles. The subtraction wraps
    // modulo 2^INPUT_WIDTH on purpose: that wrap cancels integrator overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                z_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else if (!enable) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                z_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            v_q <= x_valid;
            for (int k = 0; k < STAGES; k++) begin
                if (x_valid[k]) begin
                    c_q[k] <= x_in[k] - z_q[k];
                    z_q[k] <= x_in[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------

    // Keep the top OUTPUT_WIDTH bits of the last stage (plain truncation) and
    // pulse strobe_out for one cycle per result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_out      <= '0;
            strobe_out <= 1'b0;
        end else if (!enable) begin
            d_out      <= '0;
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
                d_out <= c_q[STAGES-1][INPUT_WIDTH-1 -: OUTPUT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_cic_decimating_comb.sv
// Bench for cic_decimating_comb. Three instances share one stimulus stream:
// STAGES=4 (16-bit out), STAGES=1 (16-bit out) and STAGES=1 (8-bit out).
// The reference model counts strobed samples per decimation period, keeps a
// history of captured samples and forms the STAGES-th difference as a
// binomial sum. Each result is due STAGES+1 edges after its capture edge.

module tb_cic_decimating_comb;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  rate = 8'd1;
    logic        strobe_in = 1'b0;
    logic [15:0] d_in = 16'h0;

    always #5 clock = ~clock;

    logic [15:0] do4, do1;
    logic [7:0]  do8;
    logic        so4, so1, so8;

    cic_decimating_comb #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16), .STAGES(4), .RATE_WIDTH(8)) u_s4 (
        .clock(clock), .reset(reset), .enable(enable), .rate(rate),
        .strobe_in(strobe_in), .d_in(d_in), .d_out(do4), .strobe_out(so4));

    cic_decimating_comb #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16), .STAGES(1), .RATE_WIDTH(8)) u_s1 (
        .clock(clock), .reset(reset), .enable(enable), .rate(rate),
        .strobe_in(strobe_in), .d_in(d_in), .d_out(do1), .strobe_out(so1));

    cic_decimating_comb #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .STAGES(1), .RATE_WIDTH(8)) u_s1n (
        .clock(clock), .reset(reset), .enable(enable), .rate(rate),
        .strobe_in(strobe_in), .d_in(d_in), .d_out(do8), .strobe_out(so8));

    int compared = 0;
    int failed   = 0;

    // ---------------- reference model ----------------
    logic [15:0] hist [0:8] = '{default: 16'h0};   // hist[0] = newest capture
    logic [47:0] exp_q0[$];                        // {due edge, value} per DUT
    logic [47:0] exp_q1[$];
    logic [47:0] exp_q2[$];
    logic        m_st [3] = '{default: 1'b0};
    logic [15:0] m_do [3] = '{default: 16'h0};
    int          cnt = 0;
    int          period = 1;
    int          cyc = 0;
    bit          need_rate = 1'b1;

    // s-th difference of the capture history: sum (-1)^j C(s,j) x[n-j]
    function automatic logic [15:0] comb_ref(input int s);
        int acc;
        int binom;
        acc   = 0;
        binom = 1;
        for (int j = 0; j <= s; j++) begin
            acc   = acc + (((j % 2) == 1) ? -binom : binom) * int'(hist[j]);
            binom = binom * (s - j) / (j + 1);
        end
        return acc[15:0];
    endfunction

    function automatic void model_clear();
        cnt = 0;
        for (int j = 0; j <= 8; j++) hist[j] = 16'h0;
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        for (int d = 0; d < 3; d++) begin
            m_st[d] = 1'b0;
            m_do[d] = 16'h0;
        end
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_clear();
            need_rate = 1'b1;
        end else begin
            cyc++;
            if (need_rate || !enable) period = (rate == 8'd0) ? 1 : int'(rate);
            need_rate = 1'b0;
            if (!enable) begin
                model_clear();
            end else begin
                if (strobe_in) begin
                    cnt++;
                    if (cnt == period) begin
                        for (int j = 8; j > 0; j--) hist[j] = hist[j-1];
                        hist[0] = d_in;
                        exp_q0.push_back({32'(cyc + 5), comb_ref(4)});
                        exp_q1.push_back({32'(cyc + 2), comb_ref(1)});
                        exp_q2.push_back({32'(cyc + 2), comb_ref(1)});
                        cnt    = 0;
                        period = (rate == 8'd0) ? 1 : int'(rate);
                    end
                end
                m_st[0] = 1'b0;
                m_st[1] = 1'b0;
                m_st[2] = 1'b0;
                if (exp_q0.size() > 0 && exp_q0[0][47:16] == 32'(cyc)) begin
                    m_st[0] = 1'b1;
                    m_do[0] = exp_q0[0][15:0];
                    void'(exp_q0.pop_front());
                end
                if (exp_q1.size() > 0 && exp_q1[0][47:16] == 32'(cyc)) begin
                    m_st[1] = 1'b1;
                    m_do[1] = exp_q1[0][15:0];
                    void'(exp_q1.pop_front());
                end
                if (exp_q2.size() > 0 && exp_q2[0][47:16] == 32'(cyc)) begin
                    m_st[2] = 1'b1;
                    m_do[2] = {8'h00, exp_q2[0][15:8]};
                    void'(exp_q2.pop_front());
                end
            end
        end
    end

    logic [42:0] obs, exp_all;
    assign obs     = {so4, do4, so1, do1, so8, do8};
    assign exp_all = {m_st[0], m_do[0], m_st[1], m_do[1], m_st[2], m_do[2][7:0]};

    logic [15:0] imp_tab [0:5] = '{16'h0001, 16'hFFFC, 16'h0006, 16'hFFFC, 16'h0001, 16'h0000};

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic stb, input logic [15:0] d);
        enable    = en;
        strobe_in = stb;
        d_in      = d;
    endtask

    // one disabled cycle: clears the DUTs and reloads rate_q
    task automatic clear_cycle();
        drive(1'b0, 1'b0, 16'h0);
        @(negedge clock);
        enable = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clock);
        compared++;
        if (obs !== 43'h0) begin
            failed++;
            $display("FAIL reset_state got=%h exp=%h", obs, 43'h0);
        end
        rate  = 8'd1;
        drive(1'b1, 1'b0, 16'h0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            compared++;
            if (obs !== exp_all) begin
                failed++;
                $display("FAIL reset_release got=%h exp=%h", obs, exp_all);
            end
        end
    endtask

    task automatic test_impulse(input bit do_clear);
        rate = 8'd1;
        if (do_clear) clear_cycle();
        for (int i = 0; i <= 10; i++) begin
            drive(1'b1, 1'b1, (i == 0) ? 16'h0001 : 16'h0000);
            @(negedge clock);
            compared++;
            if (obs !== exp_all) begin
                failed++;
                $display("FAIL impulse_model i=%0d got=%h exp=%h", i, obs, exp_all);
            end
            compared++;
            if ({so4, do4} !== {(i >= 5), (i >= 5) ? imp_tab[(i > 10) ? 5 : ((i - 5 > 5) ? 5 : i - 5)] : 16'h0}) begin
                failed++;
                $display("FAIL impulse_seq i=%0d got=%b/%h exp=%b/%h", i, so4, do4,
                         (i >= 5), (i >= 5) ? imp_tab[(i - 5 > 5) ? 5 : i - 5] : 16'h0);
            end
        end
    endtask

    task automatic test_ramp();
        logic exp_s;
        rate = 8'd4;
        clear_cycle();
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b1, 16'(i + 1));
            @(negedge clock);
            compared++;
            if (obs !== exp_all) begin
                failed++;
                $display("FAIL ramp_model i=%0d got=%h exp=%h", i, obs, exp_all);
            end
            exp_s = (i >= 5) && (((i - 5) % 4) == 0);
            compared++;
            if (so1 !== exp_s) begin
                failed++;
                $display("FAIL ramp_strobe i=%0d got=%b exp=%b", i, so1, exp_s);
            end
            if (exp_s) begin
                compared++;
                if (do1 !== 16'd4) begin
                    failed++;
                    $display("FAIL ramp_value i=%0d got=%h exp=%h", i, do1, 16'd4);
                end
            end
        end
    endtask

    task automatic test_wrap();
        rate = 8'd1;
        clear_cycle();
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      drive(1'b1, 1'b1, 16'hFFFE);
            else if (i == 1) drive(1'b1, 1'b1, 16'h0001);
            else             drive(1'b1, 1'b0, 16'h0000);
            @(negedge clock);
            compared++;
            if (obs !== exp_all) begin
                failed++;
                $display("FAIL wrap_model i=%0d got=%h exp=%h", i, obs, exp_all);
            end
            if (i == 2 || i == 3) begin
                compared++;
                if ({so1, do1, so8, do8} !== ((i == 2) ? {1'b1, 16'hFFFE, 1'b1, 8'hFF}
                                                       : {1'b1, 16'h0003, 1'b1, 8'h00})) begin
                    failed++;
                    $display("FAIL wrap_trunc i=%0d got=%b/%h %b/%h", i, so1, do1, so8, do8);
                end
            end
        end
    endtask

    task automatic test_rate_change();
        int   s;
        logic exp_s;
        rate = 8'd4;
        clear_cycle();
        for (int i = 0; i < 14; i++) begin
            rate = (i >= 2) ? 8'd2 : 8'd4;
            drive(1'b1, 1'b1, 16'($urandom));
            @(negedge clock);
            compared++;
            if (obs !== exp_all) begin
                failed++;
                $display("FAIL rate_model i=%0d got=%h exp=%h", i, obs, exp_all);
            end
            s     = i - 1;
            exp_s = (s >= 4) && (((s - 4) % 2) == 0);
            compared++;
            if (so1 !== exp_s) begin
                failed++;
                $display("FAIL rate_period i=%0d got=%b exp=%b", i, so1, exp_s);
            end
        end
        rate = 8'd0;
        for (int j = 0; j < 12; j++) begin
            drive(1'b1, 1'b1, 16'($urandom));
            @(negedge clock);
            compared++;
            if (obs !== exp_all) begin
                failed++;
                $display("FAIL rate0_model j=%0d got=%h exp=%h", j, obs, exp_all);
            end
            if (j >= 7) begin
                compared++;
                if (so1 !== 1'b1) begin
                    failed++;
                    $display("FAIL rate0_every_sample j=%0d got=%b exp=1", j, so1);
                end
            end
        end
    endtask

    task automatic test_gapped();
        logic exp_s;
        rate = 8'd3;
        clear_cycle();
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, (i % 2) == 0, 16'($urandom));
            @(negedge clock);
            compared++;
            if (obs !== exp_all) begin
                failed++;
                $display("FAIL gapped_model i=%0d got=%h exp=%h", i, obs, exp_all);
            end
            exp_s = (i >= 6) && (((i - 6) % 6) == 0);
            compared++;
            if (so1 !== exp_s) begin
                failed++;
                $display("FAIL gapped_strobe i=%0d got=%b exp=%b", i, so1, exp_s);
            end
        end
    endtask

    task automatic test_reset_mid();
        rate = 8'd1;
        clear_cycle();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 16'($urandom));
            @(negedge clock);
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if (obs !== 43'h0) begin
            failed++;
            $display("FAIL reset_async got=%h exp=%h", obs, 43'h0);
        end
        @(negedge clock);
        drive(1'b1, 1'b0, 16'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            compared++;
            if (obs !== 43'h0) begin
                failed++;
                $display("FAIL reset_no_stale i=%0d got=%h exp=%h", i, obs, 43'h0);
            end
        end
        test_impulse(1'b0);
    endtask

    task automatic test_enable_drop();
        rate = 8'd1;
        clear_cycle();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 16'($urandom));
            @(negedge clock);
        end
        drive(1'b0, 1'b1, 16'h1234);
        @(negedge clock);
        compared++;
        if (obs !== 43'h0) begin
            failed++;
            $display("FAIL enable_clear got=%h exp=%h", obs, 43'h0);
        end
        enable = 1'b1;
        test_impulse(1'b0);
    endtask

    task automatic test_random();
        rate = 8'($urandom_range(0, 5));
        clear_cycle();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) rate = 8'($urandom_range(0, 5));
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 70, 16'($urandom));
            @(negedge clock);
            compared++;
            if (obs !== exp_all) begin
                failed++;
                $display("FAIL random_model i=%0d got=%h exp=%h", i, obs, exp_all);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_impulse(1'b1);
        test_ramp();
        test_wrap();
        test_rate_change();
        test_gapped();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
